// File: rtl/irq_ctrl.sv
// irq_ctrl: latches, masks and prioritises interrupt sources for one core,
// with a claim/complete register so each request is serviced exactly once.
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            sel,
    input  logic            we,
    input  logic [3:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [NSRC-1:0] irq_src,
    output logic            irq_out
);
    logic [NSRC-1:0] src_q, pending_q, pending_d, enable_q, enable_d;
    logic [NSRC-1:0] mode_q, mode_d, insvc_q, insvc_d, elig;
    logic            irq_q, irq_d;
    logic [7:0]      claim_id;
    logic            rd, wr, claim, w1c, complete;

    assign rd       = sel && !we;
    assign wr       = sel && we;
    assign claim    = rd && addr == 4'hC;
    assign w1c      = wr && addr == 4'h0;
    assign complete = wr && addr == 4'hC;
    assign irq_out  = irq_q;

    always_comb begin
        rdata = !rd             ? 32'd0 :
                addr == 4'h0    ? 32'(pending_q) :
                addr == 4'h4    ? 32'(enable_q) :
                addr == 4'h8    ? 32'(mode_q) :
                addr == 4'hC    ? 32'(claim_id) : 32'd0;
    end

    always_comb begin
        elig      = pending_q & enable_q & ~insvc_q;
        claim_id  = 8'd0;
        pending_d = pending_q;
        insvc_d   = insvc_q;
        for (int i = NSRC - 1; i >= 0; i--)
            if (elig[i]) claim_id = 8'(i + 1);
        enable_d = (wr && addr == 4'h4) ? wdata[NSRC-1:0] : enable_q;
        mode_d   = (wr && addr == 4'h8) ? wdata[NSRC-1:0] : mode_q;
        // In edge mode a fresh edge outranks both claim and W1C clears
        for (int i = 0; i < NSRC; i++) begin
            pending_d[i] = (mode_d[i] != mode_q[i]) ? 1'b0 :
                           !mode_q[i] ? irq_src[i] :
                           (irq_src[i] && !src_q[i]) ||
                           (pending_q[i] && !(w1c && wdata[i]) &&
                            !(claim && claim_id == 8'(i + 1)));
            insvc_d[i]   = (claim && claim_id == 8'(i + 1)) ||
                           (insvc_q[i] && !(complete && wdata[7:0] == 8'(i + 1)));
        end
        irq_d = |elig;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            src_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            insvc_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            insvc_q   <= insvc_d;
            irq_q     <= irq_d;
        end
    end
endmodule
